// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-code serial link (transmit and receive sides).
//   tx_state_e  : transmitter frame state
//   Line*       : line levels for idle, start and stop chips
//   frame_len() : cycles from the first start chip to the end of the last stop chip
package rep_code_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned rep,
                                            input int unsigned baud_div);
    return (data_w + 2) * rep * baud_div;
  endfunction

endpackage

// File: rtl/rep3_serial_tx_if.sv
// Word handshake and serial line bundle for rep3_serial_tx.
//   DIN/DIN_VALID/DIN_READY : parallel word input handshake
//   TXD                     : serial chip stream (idle high)
//   BUSY                    : frame in progress
//   CHIP_STB                : pulse on the first clock of every chip
interface rep3_serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic              TXD;
  logic              BUSY;
  logic              CHIP_STB;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, TXD, BUSY, CHIP_STB
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, TXD, BUSY, CHIP_STB
  );
endinterface

// File: rtl/rep3_serial_tx_chip_timer.sv
// Chip timing for rep3_serial_tx: a divide counter (cycles per chip) feeding a repeat
// counter (chips per frame bit).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of both counters (state change)
//   en_i          : count enable (frame in progress)
//   chip_stb_o    : first cycle of a chip
//   last_chip_o   : last cycle of the last chip of a frame bit (repeat counter wrap)
module rep3_serial_tx_chip_timer #(
  parameter int unsigned REP      = 3,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic chip_stb_o,
  output logic last_chip_o
);

  localparam int unsigned DivW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned RepW = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BAUD_DIV - 1);
  localparam logic [RepW-1:0] RepMax = RepW'(REP - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic            div_wrap;

  assign div_wrap    = (div_q == DivMax);
  assign chip_stb_o  = en_i & (div_q == '0);
  assign last_chip_o = en_i & div_wrap & (rep_q == RepMax);

  always_comb begin
    div_d = div_q;
    rep_d = rep_q;
    if (clr_i) begin
      div_d = '0;
      rep_d = '0;
    end else if (en_i) begin
      if (div_wrap) begin
        div_d = '0;
        rep_d = (rep_q == RepMax) ? '0 : rep_q + RepW'(1);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      rep_q <= '0;
    end else begin
      div_q <= div_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/rep3_serial_tx.sv
// Repetition-code serial transmitter: frames a parallel word with start/stop bits and
// sends each frame bit as REP identical chips of BAUD_DIV cycles, LSB first.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of rep3_serial_tx_if (word handshake in, serial line out)
module rep3_serial_tx
  import rep_code_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REP      = 3,
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  rep3_serial_tx_if.slave bus
);

  if ((REP < 1) || ((REP % 2) == 0)) begin : g_bad_rep
    $error("rep3_serial_tx: REP must be odd and >= 1");
  end
  if (BAUD_DIV < 1) begin : g_bad_div
    $error("rep3_serial_tx: BAUD_DIV must be >= 1");
  end

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              clr;
  logic              chip_stb;
  logic              last_chip;

  rep3_serial_tx_chip_timer #(
    .REP      (REP),
    .BAUD_DIV (BAUD_DIV)
  ) u_chip_timer (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .clr_i       (clr),
    .en_i        (bus.BUSY),
    .chip_stb_o  (chip_stb),
    .last_chip_o (last_chip)
  );

  assign accept = bus.DIN_VALID & ready_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = bus.DIN;
          state_d = StStart;
        end
      end
      StStart: begin
        if (last_chip) state_d = StData;
      end
      StData: begin
        if (last_chip) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BitMax) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StStop: begin
        if (last_chip) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level and ready are computed from the next state so that TXD comes straight
  // from a flop yet lines up with the state it belongs to.
  always_comb begin
    clr     = (state_d != state_q);
    ready_d = (state_d == StIdle);
    txd_d   = LineIdle;
    case (state_d)
      StStart: txd_d = LineStart;
      StData:  txd_d = shreg_d[0];
      StStop:  txd_d = LineStop;
      default: txd_d = LineIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      txd_q     <= LineIdle;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.DIN_READY = ready_q;
  assign bus.TXD       = txd_q;
  assign bus.BUSY      = (state_q != StIdle);
  assign bus.CHIP_STB  = chip_stb;

endmodule

// File: tb/tb_rep3_serial_tx.sv
module tb_rep3_serial_tx;

  localparam int DW    = 8;
  localparam int RP    = 3;
  localparam int BD    = 4;
  localparam int FRAME = (DW + 2) * RP * BD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rep3_serial_tx_if #(.DATA_W(DW)) bus ();
  rep3_serial_tx_if #(.DATA_W(DW)) bus2 ();

  rep3_serial_tx #(
    .DATA_W   (DW),
    .REP      (RP),
    .BAUD_DIV (BD)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  rep3_serial_tx #(
    .DATA_W   (DW),
    .REP      (1),
    .BAUD_DIV (1)
  ) dut2 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame bit fb: 0 = start, 1..DW = data LSB first, DW+1 = stop.
  function automatic logic exp_bit(input logic [7:0] w, input int fb);
    if (fb == 0) return 1'b0;
    if (fb == DW + 1) return 1'b1;
    return w[fb-1];
  endfunction

  function automatic logic [3:0] vec1();
    return {bus.TXD, bus.BUSY, bus.CHIP_STB, bus.DIN_READY};
  endfunction

  function automatic logic [3:0] vec2();
    return {bus2.TXD, bus2.BUSY, bus2.CHIP_STB, bus2.DIN_READY};
  endfunction

  // Sends one word and checks every cycle of the frame plus the following idle cycle.
  // Chips are sampled mid-chip and decoded by a 2-of-3 voter; with flip set, chip 1 of
  // every bit is inverted before voting.
  task automatic run_frame(input logic [7:0] w, input logic hold, input logic [7:0] din_after,
                           input logic flip);
    logic       chips [(DW+2)*RP];
    logic [7:0] dec;
    logic       a, b, c, v;
    check("pre_ready", bus.DIN_READY, 1);
    bus.DIN       = w;
    bus.DIN_VALID = 1'b1;
    @(posedge clk); #1;
    bus.DIN       = din_after;
    bus.DIN_VALID = hold;
    for (int cyc = 0; cyc < FRAME; cyc++) begin
      logic ex;
      ex = exp_bit(w, cyc / (RP * BD));
      check("frame", vec1(), {ex, 1'b1, (cyc % BD) == 0, 1'b0});
      if ((cyc % BD) == BD / 2) chips[cyc/BD] = bus.TXD;
      @(posedge clk); #1;
    end
    check("idle_gap", vec1(), 4'b1001);
    dec = '0;
    for (int fb = 0; fb < DW + 2; fb++) begin
      a = chips[fb*RP];
      b = chips[fb*RP+1] ^ flip;
      c = chips[fb*RP+2];
      v = (a & b) | (a & c) | (b & c);
      if (fb == 0) check("vote_start", v, 0);
      else if (fb == DW + 1) check("vote_stop", v, 1);
      else dec[fb-1] = v;
    end
    check("decode", dec, w);
  endtask

  initial begin
    logic [9:0] pat;
    bus.DIN        = '0;
    bus.DIN_VALID  = 1'b0;
    bus2.DIN       = '0;
    bus2.DIN_VALID = 1'b0;

    // Reset and idle
    #12;
    check("rst_hold", vec1(), 4'b1000);
    check("rst_hold2", vec2(), 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle", vec1(), 4'b1001);
    end

    // Single frame
    run_frame(8'hA5, 1'b0, 8'h00, 1'b0);

    // Back-to-back with DIN_VALID held high
    run_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    run_frame(8'hFF, 1'b0, 8'h5A, 1'b0);

    // Random words through the voter with one corrupted chip per bit
    for (int n = 0; n < 256; n++) begin
      logic [7:0] w, junk;
      w    = 8'($urandom_range(0, 255));
      junk = 8'($urandom_range(0, 255));
      run_frame(w, 1'b0, junk, 1'b1);
    end

    // Reset at cycle 50 of a frame
    bus.DIN       = 8'h96;
    bus.DIN_VALID = 1'b1;
    @(posedge clk); #1;
    bus.DIN_VALID = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_txd", bus.TXD, exp_bit(8'h96, 50 / (RP * BD)));
    check("pre_rst_busy", bus.BUSY, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", vec1(), 4'b1000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", vec1(), 4'b1001);
    end
    run_frame(8'hC3, 1'b0, 8'h00, 1'b0);

    // REP=1, BAUD_DIV=1 instance
    pat = 10'b1001111000;
    check("deg_pre", vec2(), 4'b1001);
    bus2.DIN       = 8'h3C;
    bus2.DIN_VALID = 1'b1;
    @(posedge clk); #1;
    bus2.DIN_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("deg_frame", vec2(), {pat[i], 1'b1, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    check("deg_idle", vec2(), 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
Serial repetition-code transmitter, the encoding end of the team's majority-vote (2-of-3) receive path.
- Accepts a parallel data word over a valid/ready handshake.
- Frames the word with start and stop bits.
- Sends every frame bit as REP identical consecutive chips on a single line, so a downstream majority voter can correct one corrupted chip per bit.

Parameters:
DATA_W, 8, data word width in bits.
REP, 3, chips per frame bit; must be odd and >= 1. Elaboration error otherwise.
BAUD_DIV, 4, clock cycles per chip; must be >= 1. Elaboration error otherwise.

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
RST_N  input  1  asynchronous, active-low reset.
DIN  input  DATA_W  word to transmit; sampled only on the accept cycle.
DIN_VALID  input  1  DIN holds a word to send.
DIN_READY  output  1  block can accept a word this cycle.
TXD  output  1  serial chip stream, registered; idle level is 1.
BUSY  output  1  frame in progress (any state other than IDLE).
CHIP_STB  output  1  one-cycle pulse on the first clock of every chip.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values, applied immediately on RST_N low: TXD=1, DIN_READY=0, BUSY=0, CHIP_STB=0, state=IDLE, all counters 0, shift register 0.
- After RST_N deasserts, DIN_READY=1 from the first clock edge onward.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TXD=1, DIN_READY=1, BUSY=0.
  - Accept occurs when DIN_VALID=1 and DIN_READY=1 on a rising edge.
  - On accept: latch DIN into the shift register and go to START.
  - Latency: TXD shows the first start chip on the cycle after the accept edge. CHIP_STB=1 on that same cycle.
- START: REP chips of 0.
- DATA:
  - DATA_W bits, LSB first.
  - Each bit is held on TXD for REP chips.
  - Shift the register right after the last chip of each bit.
- STOP: REP chips of 1. After the last stop chip ends, go to IDLE.
- Chip timing:
  - Each chip lasts BAUD_DIV cycles, counted by a divide counter (0..BAUD_DIV-1).
  - A repeat counter (0..REP-1) advances when the divide counter wraps.
  - A bit counter (0..DATA_W-1) advances when the repeat counter wraps in DATA.
  - All counters reset to 0 on every state change.
- Frame length: exactly (DATA_W+2)*REP*BAUD_DIV cycles from the first start chip through the end of the last stop chip.
- Back-to-back frames: IDLE always lasts at least one cycle (TXD=1) between frames. DIN_READY is 0 for the whole frame and 1 in that IDLE cycle.
- DIN_VALID deasserting while not ready has no effect. DIN changes during a frame are ignored.
- DIN_VALID held high continuously: a new word is accepted on each IDLE cycle, giving a frame period of frame length + 1 cycle.
- REP=1: degenerates to plain 8N1-style framing; must work.
- BAUD_DIV=1: CHIP_STB stays high for the entire frame.
- Reset mid-frame: the frame is aborted immediately. TXD returns to 1 asynchronously and no partial frame resumes after release.
- TXD is driven from a flop: no glitches and no combinational path from inputs to TXD.

Decomposition:
- Shared package rep_code_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the idle/start/stop line-level constants;
  - a frame-length constant function of (DATA_W, REP, BAUD_DIV), also used by the receive side and the bench.
- One natural sub-module, chip_timer:
  - contains the divide counter and repeat counter;
  - outputs chip_stb and last_chip (repeat counter wrap);
  - takes a clear input driven on state change.

Test Plan:
(All scenarios use DATA_W=8, REP=3, BAUD_DIV=4 unless noted, giving a 120-cycle frame.)
- Reset/idle: hold RST_N low, then release with DIN_VALID=0 for 20 cycles -> TXD=1, BUSY=0, DIN_READY=1 after the first edge, CHIP_STB never pulses.
- Single frame, DIN=0xA5:
  - TXD=0 for 12 cycles.
  - Then 12-cycle groups 1,0,1,0,0,1,0,1.
  - Then 1 for 12 cycles.
  - BUSY high for exactly 120 cycles; CHIP_STB pulses 30 times, 4 cycles apart.
- Back-to-back: DIN_VALID held high with 0x00 then 0xFF -> exactly one idle cycle (TXD=1, DIN_READY=1) between frames; second frame data chips all 1.
- Round-trip: feed TXD into the majority-vote receiver model and flip one chip per bit (chip index 1) across 256 random words -> all words decode correctly.
- Reset mid-frame: assert RST_N at cycle 50 of a frame -> TXD=1 within the same cycle. After release the line stays idle until a new handshake; the next frame is a complete 120-cycle frame.
- Degenerate parameters: REP=1, BAUD_DIV=1, DIN=0x3C -> 10-cycle frame with TXD 0,0,0,1,1,1,1,0,0,1 and CHIP_STB high throughout.
